// File: rtl/mig_port_arbiter_if.sv
// Bundle of the requester-side and MIG app-side signals around mig_port_arbiter.
// The master modport is the arbiter; the slave modport is its environment (clients + MIG).
interface mig_port_arbiter_if #(
   parameter int unsigned ADDR_WIDTH     = 27,
   parameter int unsigned APP_DATA_WIDTH = 256
);
   logic                      r0_req;
   logic                      r0_wr;
   logic [ADDR_WIDTH-1:0]     r0_addr;
   logic [APP_DATA_WIDTH-1:0] r0_wdata;
   logic                      r0_ack;
   logic                      r0_rd_valid;
   logic                      r1_req;
   logic                      r1_wr;
   logic [ADDR_WIDTH-1:0]     r1_addr;
   logic [APP_DATA_WIDTH-1:0] r1_wdata;
   logic                      r1_ack;
   logic                      r1_rd_valid;
   logic [APP_DATA_WIDTH-1:0] rd_data;
   logic                      app_rdy;
   logic                      app_en;
   logic [2:0]                app_cmd;
   logic [ADDR_WIDTH-1:0]     app_addr;
   logic                      app_wdf_rdy;
   logic                      app_wdf_wren;
   logic                      app_wdf_end;
   logic [APP_DATA_WIDTH-1:0] app_wdf_data;
   logic                      app_rd_data_valid;
   logic [APP_DATA_WIDTH-1:0] app_rd_data;

   modport master (
      input  r0_req, r0_wr, r0_addr, r0_wdata,
      input  r1_req, r1_wr, r1_addr, r1_wdata,
      input  app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data,
      output r0_ack, r0_rd_valid, r1_ack, r1_rd_valid, rd_data,
      output app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end, app_wdf_data
   );

   modport slave (
      output r0_req, r0_wr, r0_addr, r0_wdata,
      output r1_req, r1_wr, r1_addr, r1_wdata,
      output app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data,
      input  r0_ack, r0_rd_valid, r1_ack, r1_rd_valid, rd_data,
      input  app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end, app_wdf_data
   );
endinterface

// File: rtl/mig_port_arbiter.sv
// Round-robin arbiter sharing one MIG app port between two requesters.
// One BL8 command in flight at a time; read requesters are queued in a tag FIFO
// so returned read data is steered back in issue order.
// Optional statistics outputs are enabled by defining MIG_ARB_STATS_EN.
module mig_port_arbiter #(
   parameter int unsigned ADDR_WIDTH     = 27,
   parameter int unsigned APP_DATA_WIDTH = 256,
   parameter int unsigned TAG_DEPTH      = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   output logic                 error,
`ifdef MIG_ARB_STATS_EN
   output logic [31:0]          grant_cnt0,
   output logic [31:0]          grant_cnt1,
   output logic [$clog2(TAG_DEPTH):0] rd_out_max,
`endif
   mig_port_arbiter_if.master   bus
);

   localparam int unsigned PW = $clog2(TAG_DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t               state;
   logic                 last_grant;
   logic                 grant_id;
   logic [TAG_DEPTH-1:0] tag_mem;
   logic [PW-1:0]        wr_ptr;
   logic [PW-1:0]        rd_ptr;
   logic [CW-1:0]        tag_cnt;

   logic                 tag_full;
   logic                 elig0;
   logic                 elig1;
   logic                 pick1;
   logic                 sel_wr;
   logic                 issue_done;
   logic                 push;
   logic                 pop;

   // Arbitration, handshake completion and tag FIFO control.
   always_comb begin
      tag_full   = (tag_cnt >= CW'(TAG_DEPTH));
      elig0      = bus.r0_req & (bus.r0_wr | ~tag_full);
      elig1      = bus.r1_req & (bus.r1_wr | ~tag_full);
      pick1      = elig1 & (~elig0 | ~last_grant);
      sel_wr     = pick1 ? bus.r1_wr : bus.r0_wr;
      issue_done = (state == ISSUE) & ~reset
                   & (~bus.app_en | bus.app_rdy)
                   & (~bus.app_wdf_wren | bus.app_wdf_rdy);
      push       = issue_done & bus.app_cmd[0];
      pop        = bus.app_rd_data_valid & (tag_cnt != '0);
   end

   // Ack fires in the cycle the last outstanding handshake completes.
   assign bus.r0_ack      = issue_done & ~grant_id;
   assign bus.r1_ack      = issue_done &  grant_id;
   assign bus.app_wdf_end = 1'b1;

   // Command FSM, tag FIFO and read-return steering.
   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= IDLE;
         last_grant       <= 1'b1;
         grant_id         <= 1'b0;
         tag_mem          <= '0;
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         tag_cnt          <= '0;
         error            <= 1'b0;
         bus.app_en       <= 1'b0;
         bus.app_wdf_wren <= 1'b0;
         bus.app_cmd      <= 3'b000;
         bus.app_addr     <= '0;
         bus.app_wdf_data <= '0;
         bus.r0_rd_valid  <= 1'b0;
         bus.r1_rd_valid  <= 1'b0;
         bus.rd_data      <= '0;
      end else begin
         bus.r0_rd_valid <= pop & ~tag_mem[rd_ptr];
         bus.r1_rd_valid <= pop &  tag_mem[rd_ptr];
         if (bus.app_rd_data_valid) begin
            bus.rd_data <= bus.app_rd_data;
            if (tag_cnt == '0)
               error <= 1'b1;
         end
         if (push) begin
            tag_mem[wr_ptr] <= grant_id;
            wr_ptr          <= wr_ptr + PW'(1);
         end
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         tag_cnt <= tag_cnt + CW'(push) - CW'(pop);

         case (state)
            IDLE: begin
               if (elig0 | elig1) begin
                  grant_id         <= pick1;
                  last_grant       <= pick1;
                  bus.app_en       <= 1'b1;
                  bus.app_wdf_wren <= sel_wr;
                  bus.app_cmd      <= sel_wr ? 3'b000 : 3'b001;
                  bus.app_addr     <= pick1 ? bus.r1_addr : bus.r0_addr;
                  bus.app_wdf_data <= pick1 ? bus.r1_wdata : bus.r0_wdata;
                  state            <= ISSUE;
               end
            end
            ISSUE: begin
               if (bus.app_en & bus.app_rdy)
                  bus.app_en <= 1'b0;
               if (bus.app_wdf_wren & bus.app_wdf_rdy)
                  bus.app_wdf_wren <= 1'b0;
               if (issue_done)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef MIG_ARB_STATS_EN
   // Per-requester grant counters and outstanding-read high-water mark.
   always_ff @(posedge clk) begin
      if (reset) begin
         grant_cnt0 <= '0;
         grant_cnt1 <= '0;
         rd_out_max <= '0;
      end else begin
         if (bus.r0_ack)
            grant_cnt0 <= grant_cnt0 + 32'd1;
         if (bus.r1_ack)
            grant_cnt1 <= grant_cnt1 + 32'd1;
         if (tag_cnt > rd_out_max)
            rd_out_max <= tag_cnt;
      end
   end
`endif

endmodule

// File: tb/tb_mig_port_arbiter.sv
// Directed, table-driven bench for mig_port_arbiter plus hand-written multi-cycle sequences.
module tb_mig_port_arbiter;

   localparam int unsigned AW = 27;
   localparam int unsigned DW = 256;

   logic clk;
   logic reset;
   logic error;
`ifdef MIG_ARB_STATS_EN
   logic [31:0] grant_cnt0;
   logic [31:0] grant_cnt1;
   logic [4:0]  rd_out_max;
`endif

   mig_port_arbiter_if #(.ADDR_WIDTH(AW), .APP_DATA_WIDTH(DW)) bus ();

   mig_port_arbiter #(.ADDR_WIDTH(AW), .APP_DATA_WIDTH(DW), .TAG_DEPTH(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .error      (error),
`ifdef MIG_ARB_STATS_EN
      .grant_cnt0 (grant_cnt0),
      .grant_cnt1 (grant_cnt1),
      .rd_out_max (rd_out_max),
`endif
      .bus        (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst, q0, w0;
      logic [31:0] a0, d0;
      logic        q1, w1;
      logic [31:0] a1, d1;
      logic        rdy, wrdy, rdv;
      logic [31:0] rdd;
      logic        en, wren;
      logic [2:0]  cmd;
      logic [31:0] addr, wdata;
      logic        ack0, ack1, rv0, rv1;
      logic [31:0] rdata;
      logic        err;
   } vec_t;

   vec_t vecs[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic add(
      input logic rst, q0, w0, input logic [31:0] a0, d0,
      input logic q1, w1, input logic [31:0] a1, d1,
      input logic rdy, wrdy, rdv, input logic [31:0] rdd,
      input logic en, wren, input logic [2:0] cmd, input logic [31:0] addr, wdata,
      input logic ack0, ack1, rv0, rv1, input logic [31:0] rdata, input logic err);
      vec_t v;
      v.rst = rst; v.q0 = q0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
      v.q1 = q1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
      v.rdy = rdy; v.wrdy = wrdy; v.rdv = rdv; v.rdd = rdd;
      v.en = en; v.wren = wren; v.cmd = cmd; v.addr = addr; v.wdata = wdata;
      v.ack0 = ack0; v.ack1 = ack1; v.rv0 = rv0; v.rv1 = rv1; v.rdata = rdata; v.err = err;
      vecs.push_back(v);
   endtask

   task automatic drive(input vec_t v);
      reset                 = v.rst;
      bus.r0_req            = v.q0;
      bus.r0_wr             = v.w0;
      bus.r0_addr           = AW'(v.a0);
      bus.r0_wdata          = DW'(v.d0);
      bus.r1_req            = v.q1;
      bus.r1_wr             = v.w1;
      bus.r1_addr           = AW'(v.a1);
      bus.r1_wdata          = DW'(v.d1);
      bus.app_rdy           = v.rdy;
      bus.app_wdf_rdy       = v.wrdy;
      bus.app_rd_data_valid = v.rdv;
      bus.app_rd_data       = DW'(v.rdd);
   endtask

   initial begin
      vec_t idle;
      int   n;
      int   n1;
      bit   seen;

      clk = 1'b0;
      idle = '{default: '0};
      idle.rdy = 1'b1; idle.wrdy = 1'b1;
      drive(idle);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;

      // Reset values
      chk("rst_app_en", 256'(bus.app_en), 256'(0));
      chk("rst_wren", 256'(bus.app_wdf_wren), 256'(0));
      chk("rst_cmd", 256'(bus.app_cmd), 256'(0));
      chk("rst_addr", 256'(bus.app_addr), 256'(0));
      chk("rst_wdata", 256'(bus.app_wdf_data), 256'(0));
      chk("rst_acks", 256'({bus.r0_ack, bus.r1_ack, bus.r0_rd_valid, bus.r1_rd_valid}), 256'(0));
      chk("rst_error", 256'(error), 256'(0));
      chk("wdf_end", 256'(bus.app_wdf_end), 256'(1));

      //   rst q0 w0 a0      d0  q1 w1 a1     d1      rdy wrdy rdv rdd    en wr cmd addr    wdata   a0 a1 v0 v1 rdata  err
      // single write, everything ready
      add(0, 1, 1, 'h1ff0, 1,  0, 0, 0,     0,      1, 1, 0, 0,      0, 0, 0, 0,      0,      0, 0, 0, 0, 0,     0);
      add(0, 1, 1, 'h1ff0, 1,  0, 0, 0,     0,      1, 1, 0, 0,      1, 1, 0, 'h1ff0, 1,      1, 0, 0, 0, 0,     0);
      add(0, 0, 0, 0,      0,  0, 0, 0,     0,      1, 1, 0, 0,      0, 0, 0, 0,      0,      0, 0, 0, 0, 0,     0);
      // write with write-data stalled three cycles
      add(0, 0, 0, 0,      0,  1, 1, 'h40,  'habc,  1, 0, 0, 0,      0, 0, 0, 0,      0,      0, 0, 0, 0, 0,     0);
      add(0, 0, 0, 0,      0,  1, 1, 'h40,  'habc,  1, 0, 0, 0,      1, 1, 0, 'h40,   'habc,  0, 0, 0, 0, 0,     0);
      add(0, 0, 0, 0,      0,  1, 1, 'h40,  'habc,  1, 0, 0, 0,      0, 1, 0, 0,      'habc,  0, 0, 0, 0, 0,     0);
      add(0, 0, 0, 0,      0,  1, 1, 'h40,  'habc,  1, 0, 0, 0,      0, 1, 0, 0,      'habc,  0, 0, 0, 0, 0,     0);
      add(0, 0, 0, 0,      0,  1, 1, 'h40,  'habc,  1, 1, 0, 0,      0, 1, 0, 0,      'habc,  0, 1, 0, 0, 0,     0);
      add(0, 0, 0, 0,      0,  0, 0, 0,     0,      1, 1, 0, 0,      0, 0, 0, 0,      0,      0, 0, 0, 0, 0,     0);
      // both read continuously: r0, r1, r0, r1
      add(0, 1, 0, 'h100,  0,  1, 0, 'h200, 0,      1, 1, 0, 0,      0, 0, 0, 0,      0,      0, 0, 0, 0, 0,     0);
      add(0, 1, 0, 'h100,  0,  1, 0, 'h200, 0,      1, 1, 0, 0,      1, 0, 1, 'h100,  0,      1, 0, 0, 0, 0,     0);
      add(0, 1, 0, 'h100,  0,  1, 0, 'h200, 0,      1, 1, 0, 0,      0, 0, 0, 0,      0,      0, 0, 0, 0, 0,     0);
      add(0, 1, 0, 'h100,  0,  1, 0, 'h200, 0,      1, 1, 0, 0,      1, 0, 1, 'h200,  0,      0, 1, 0, 0, 0,     0);
      add(0, 1, 0, 'h100,  0,  1, 0, 'h200, 0,      1, 1, 0, 0,      0, 0, 0, 0,      0,      0, 0, 0, 0, 0,     0);
      add(0, 1, 0, 'h100,  0,  1, 0, 'h200, 0,      1, 1, 0, 0,      1, 0, 1, 'h100,  0,      1, 0, 0, 0, 0,     0);
      add(0, 0, 0, 0,      0,  1, 0, 'h200, 0,      1, 1, 0, 0,      0, 0, 0, 0,      0,      0, 0, 0, 0, 0,     0);
      add(0, 0, 0, 0,      0,  1, 0, 'h200, 0,      1, 1, 0, 0,      1, 0, 1, 'h200,  0,      0, 1, 0, 0, 0,     0);
      // read returns steered in issue order
      add(0, 0, 0, 0,      0,  0, 0, 0,     0,      1, 1, 1, 'h11,   0, 0, 0, 0,      0,      0, 0, 0, 0, 0,     0);
      add(0, 0, 0, 0,      0,  0, 0, 0,     0,      1, 1, 1, 'h22,   0, 0, 0, 0,      0,      0, 0, 1, 0, 'h11,  0);
      add(0, 0, 0, 0,      0,  0, 0, 0,     0,      1, 1, 1, 'h33,   0, 0, 0, 0,      0,      0, 0, 0, 1, 'h22,  0);
      add(0, 0, 0, 0,      0,  0, 0, 0,     0,      1, 1, 1, 'h44,   0, 0, 0, 0,      0,      0, 0, 1, 0, 'h33,  0);
      add(0, 0, 0, 0,      0,  0, 0, 0,     0,      1, 1, 0, 0,      0, 0, 0, 0,      0,      0, 0, 0, 1, 'h44,  0);
      add(0, 0, 0, 0,      0,  0, 0, 0,     0,      1, 1, 0, 0,      0, 0, 0, 0,      0,      0, 0, 0, 0, 0,     0);
      // stray read data with empty FIFO: sticky error, cleared by reset
      add(0, 0, 0, 0,      0,  0, 0, 0,     0,      1, 1, 1, 'h55,   0, 0, 0, 0,      0,      0, 0, 0, 0, 0,     0);
      add(0, 0, 0, 0,      0,  0, 0, 0,     0,      1, 1, 0, 0,      0, 0, 0, 0,      0,      0, 0, 0, 0, 0,     1);
      add(0, 0, 0, 0,      0,  0, 0, 0,     0,      1, 1, 0, 0,      0, 0, 0, 0,      0,      0, 0, 0, 0, 0,     1);
      add(1, 0, 0, 0,      0,  0, 0, 0,     0,      1, 1, 0, 0,      0, 0, 0, 0,      0,      0, 0, 0, 0, 0,     1);
      add(0, 0, 0, 0,      0,  0, 0, 0,     0,      1, 1, 0, 0,      0, 0, 0, 0,      0,      0, 0, 0, 0, 0,     0);

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i]);
         #1;
         chk($sformatf("row%0d_ctl", i),
             256'({bus.app_en, bus.app_wdf_wren, bus.r0_ack, bus.r1_ack,
                   bus.r0_rd_valid, bus.r1_rd_valid, error}),
             256'({vecs[i].en, vecs[i].wren, vecs[i].ack0, vecs[i].ack1,
                   vecs[i].rv0, vecs[i].rv1, vecs[i].err}));
         if (vecs[i].en) begin
            chk($sformatf("row%0d_cmd", i), 256'(bus.app_cmd), 256'(vecs[i].cmd));
            chk($sformatf("row%0d_addr", i), 256'(bus.app_addr), 256'(vecs[i].addr));
         end
         if (vecs[i].wren)
            chk($sformatf("row%0d_wdata", i), 256'(bus.app_wdf_data), 256'(vecs[i].wdata));
         if (vecs[i].rv0 | vecs[i].rv1)
            chk($sformatf("row%0d_rdata", i), 256'(bus.rd_data), 256'(vecs[i].rdata));
      end

      // r1 fills the tag FIFO with 16 reads; the 17th must wait
      bus.r1_req = 1'b1; bus.r1_wr = 1'b0; bus.r1_addr = AW'(32'h300);
      n = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk); #1;
         if (bus.r1_ack) n++;
      end
      chk("full_read_acks", 256'(n), 256'(16));
      chk("full_no_cmd", 256'(bus.app_en), 256'(0));

      // a write still arbitrates while reads are blocked
      bus.r0_req = 1'b1; bus.r0_wr = 1'b1; bus.r0_addr = AW'(32'h500); bus.r0_wdata = DW'(32'h77);
      seen = 1'b0; n1 = 0;
      for (int c = 0; c < 8 && !seen; c++) begin
         @(negedge clk); #1;
         if (bus.r1_ack) n1++;
         if (bus.r0_ack) seen = 1'b1;
      end
      chk("full_write_ack", 256'(seen), 256'(1));
      chk("full_write_addr", 256'(bus.app_addr), 256'(32'h500));
      chk("full_r1_blocked", 256'(n1), 256'(0));
      bus.r0_req = 1'b0;

      // one return frees a slot for r1
      bus.app_rd_data_valid = 1'b1; bus.app_rd_data = DW'(32'h99);
      @(negedge clk);
      bus.app_rd_data_valid = 1'b0;
      #1;
      chk("full_ret_valid", 256'({bus.r0_rd_valid, bus.r1_rd_valid}), 256'(2'b01));
      chk("full_ret_data", 256'(bus.rd_data), 256'(32'h99));
      seen = 1'b0;
      for (int c = 0; c < 8 && !seen; c++) begin
         @(negedge clk); #1;
         if (bus.r1_ack) seen = 1'b1;
      end
      chk("read17_granted", 256'(seen), 256'(1));
      bus.r1_req = 1'b0;

      // reset while a command is stuck waiting for app_rdy
      bus.app_rdy = 1'b0;
      bus.r0_req = 1'b1; bus.r0_wr = 1'b1; bus.r0_addr = AW'(32'h600);
      seen = 1'b0;
      for (int c = 0; c < 8 && !seen; c++) begin
         @(negedge clk); #1;
         if (bus.app_en) seen = 1'b1;
      end
      chk("stall_cmd_issued", 256'(seen), 256'(1));
      @(negedge clk); #1;
      chk("stall_no_ack", 256'(bus.r0_ack), 256'(0));
      reset = 1'b1; bus.r0_req = 1'b0;
      #1;
      chk("rst_cycle_no_ack", 256'(bus.r0_ack), 256'(0));
      @(negedge clk); #1;
      chk("mid_rst_app_en", 256'({bus.app_en, bus.app_wdf_wren, bus.r0_ack}), 256'(0));
      reset = 1'b0; bus.app_rdy = 1'b1;
      bus.app_rd_data_valid = 1'b1;
      @(negedge clk);
      bus.app_rd_data_valid = 1'b0;
      #1;
      chk("flushed_fifo_err", 256'(error), 256'(1));
      chk("flushed_no_valid", 256'({bus.r0_rd_valid, bus.r1_rd_valid}), 256'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
